string_receiver: RTL and testbench

Decoder for the one-wire NRZ pixel waveform that `string_driver` produces. It samples a serial LED data line in the `clk_20` domain and classifies each high pulse as a 0 or 1 bit. It assembles bits MSB-first into 24-bit pixel words and detects the latch (reset) gap that ends a frame. The block sits on a loopback of `led_sdi` so that transmitted frames can be checked in hardware and on the bench.

---
 rtl/string_receiver_if.sv | 24 ++
 rtl/string_receiver.sv | 169 ++++++++++++++++
 tb/tb_string_receiver.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/string_receiver_if.sv
// rtl/string_receiver_if.sv - serial LED line and decoded pixel/frame outputs of string_receiver
interface string_receiver_if #(
  parameter int PIXEL_WIDTH = 24,
  parameter int COUNT_WIDTH = 16
);
  logic                   sdi;
  logic [PIXEL_WIDTH-1:0] pixel_data;
  logic                   pixel_valid;
  logic                   frame_done;
  logic [COUNT_WIDTH-1:0] pixel_count;
  logic                   bit_err;
  logic                   frame_err;
  logic                   synced;

  modport master (
    output sdi,
    input  pixel_data, pixel_valid, frame_done, pixel_count, bit_err, frame_err, synced
  );

  modport slave (
    input  sdi,
    output pixel_data, pixel_valid, frame_done, pixel_count, bit_err, frame_err, synced
  );
endinterface

// File: rtl/string_receiver.sv
// rtl/string_receiver.sv - one-wire NRZ LED waveform decoder: pulse-width bits, 24-bit pixels, latch-gap frames
module string_receiver #(
  parameter int CLK_PERIOD_NS = 50,
  parameter int T_MIN_HIGH_NS = 150,
  parameter int T_THRESH_NS   = 600,
  parameter int T_MAX_HIGH_NS = 1200,
  parameter int T_RESET_NS    = 50000,
  parameter int PIXEL_WIDTH   = 24,
  parameter int COUNT_WIDTH   = 16
) (
  input logic               clk_i,
  input logic               reset_i,
  string_receiver_if.slave  rx
);
  localparam int CW = 11;
  localparam int BW = $clog2(PIXEL_WIDTH + 1);
  localparam logic [CW-1:0] MIN_CYC    = CW'(T_MIN_HIGH_NS / CLK_PERIOD_NS);
  localparam logic [CW-1:0] THRESH_CYC = CW'(T_THRESH_NS / CLK_PERIOD_NS);
  localparam logic [CW-1:0] MAX_CYC    = CW'(T_MAX_HIGH_NS / CLK_PERIOD_NS);
  localparam logic [CW-1:0] RESET_CYC  = CW'(T_RESET_NS / CLK_PERIOD_NS);
  localparam logic [BW-1:0] LAST_BIT   = BW'(PIXEL_WIDTH - 1);

  typedef enum logic [1:0] {ST_SYNC, ST_LOW, ST_HIGH} state_e;

  state_e                 state_q, state_d;
  logic                   sdi_meta_q, sdi_s_q, sdi_d_q;
  logic [CW-1:0]          high_cnt_q, high_cnt_d;
  logic [CW-1:0]          low_cnt_q, low_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [COUNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIXEL_WIDTH-2:0] shift_q, shift_d;
  logic [PIXEL_WIDTH-1:0] pixel_data_q, pixel_data_d;
  logic [COUNT_WIDTH-1:0] pixel_count_q, pixel_count_d;
  logic                   pixel_valid_q, pixel_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   bit_err_q, bit_err_d;
  logic                   rise, fall, go_sync, new_bit;

  assign rise    = sdi_s_q & ~sdi_d_q;
  assign fall    = ~sdi_s_q & sdi_d_q;
  assign new_bit = (high_cnt_q >= THRESH_CYC);

  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    shift_d       = shift_q;
    pixel_data_d  = pixel_data_q;
    pixel_count_d = pixel_count_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    bit_err_d     = 1'b0;
    go_sync       = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (sdi_s_q) begin
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_cnt_q + CW'(1);
          if (low_cnt_d == RESET_CYC) state_d = ST_LOW;
        end
      end

      ST_LOW: begin
        if (rise) begin
          // the rise cycle itself is the first high cycle of the pulse
          high_cnt_d = CW'(1);
          state_d    = ST_HIGH;
        end else if (low_cnt_q != RESET_CYC) begin
          low_cnt_d = low_cnt_q + CW'(1);
          if (low_cnt_d == RESET_CYC) begin
            if (bit_cnt_q != '0 || pix_cnt_q != '0) begin
              frame_done_d  = 1'b1;
              pixel_count_d = pix_cnt_q;
            end
            frame_err_d = (bit_cnt_q != '0);
            bit_cnt_d   = '0;
            pix_cnt_d   = '0;
            shift_d     = '0;
          end
        end
      end

      ST_HIGH: begin
        if (fall) begin
          if (high_cnt_q < MIN_CYC) begin
            bit_err_d = 1'b1;
            go_sync   = 1'b1;
          end else begin
            shift_d   = {shift_q[PIXEL_WIDTH-3:0], new_bit};
            bit_cnt_d = bit_cnt_q + BW'(1);
            low_cnt_d = CW'(1);
            state_d   = ST_LOW;
            if (bit_cnt_q == LAST_BIT) begin
              pixel_data_d  = {shift_q, new_bit};
              pixel_valid_d = 1'b1;
              bit_cnt_d     = '0;
              if (!(&pix_cnt_q)) pix_cnt_d = pix_cnt_q + COUNT_WIDTH'(1);
            end
          end
        end else if (high_cnt_q >= MAX_CYC) begin
          bit_err_d = 1'b1;
          go_sync   = 1'b1;
        end else begin
          high_cnt_d = high_cnt_q + CW'(1);
        end
      end

      default: go_sync = 1'b1;
    endcase

    if (go_sync) begin
      state_d   = ST_SYNC;
      low_cnt_d = '0;
      bit_cnt_d = '0;
      pix_cnt_d = '0;
      shift_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_SYNC;
      sdi_meta_q    <= 1'b0;
      sdi_s_q       <= 1'b0;
      sdi_d_q       <= 1'b0;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      pix_cnt_q     <= '0;
      shift_q       <= '0;
      pixel_data_q  <= '0;
      pixel_count_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      bit_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sdi_meta_q    <= rx.sdi;
      sdi_s_q       <= sdi_meta_q;
      sdi_d_q       <= sdi_s_q;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      shift_q       <= shift_d;
      pixel_data_q  <= pixel_data_d;
      pixel_count_q <= pixel_count_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      bit_err_q     <= bit_err_d;
    end
  end

  assign rx.pixel_data  = pixel_data_q;
  assign rx.pixel_valid = pixel_valid_q;
  assign rx.frame_done  = frame_done_q;
  assign rx.pixel_count = pixel_count_q;
  assign rx.bit_err     = bit_err_q;
  assign rx.frame_err   = frame_err_q;
  assign rx.synced      = (state_q != ST_SYNC);
endmodule

// File: tb/tb_string_receiver.sv
// tb/tb_string_receiver.sv - scoreboard bench for string_receiver
`timescale 1ns/1ps
module tb_string_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   n_pv = 0, n_fd = 0, n_be = 0;
  int   pv0, fd0, be0;
  logic [23:0] exp_pix[$];
  logic [16:0] exp_frm[$];

  string_receiver_if #(.PIXEL_WIDTH(24), .COUNT_WIDTH(16)) bus ();

  string_receiver dut (
    .clk_i   (clk),
    .reset_i (rst),
    .rx      (bus.slave)
  );

  always #25 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.sdi = 1'b1;
    repeat (hi) @(negedge clk);
    bus.sdi = 1'b0;
    last_fall_cyc = cyc;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (v[i]) pulse(16, 9);
      else      pulse(8, 17);
    end
  endtask

  task automatic send_pixel(input logic [23:0] p);
    exp_pix.push_back(p);
    send_bits(p, 24);
  endtask

  task automatic idle(input int n);
    bus.sdi = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    pv0 = n_pv; fd0 = n_fd; be0 = n_be;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pixel_valid) begin
        n_pv++;
        if (exp_pix.size() == 0) chk("pv_unexpected", 1, 0);
        else chk("pixel_data", bus.pixel_data, exp_pix.pop_front());
        chk("pv_latency", cyc - last_fall_cyc, 3);
        chk("pv_fd_overlap", bus.frame_done, 0);
      end
      if (bus.frame_done) begin
        logic [16:0] f;
        n_fd++;
        if (exp_frm.size() == 0) chk("fd_unexpected", 1, 0);
        else begin
          f = exp_frm.pop_front();
          chk("pixel_count", bus.pixel_count, f[15:0]);
          chk("frame_err", bus.frame_err, f[16]);
        end
      end else begin
        chk("frame_err_alone", bus.frame_err, 0);
      end
      if (bus.bit_err) n_be++;
    end
  end

  initial begin
    bus.sdi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pixel_data", bus.pixel_data, 0);
    chk("rst_pixel_valid", bus.pixel_valid, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_pixel_count", bus.pixel_count, 0);
    chk("rst_bit_err", bus.bit_err, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_synced", bus.synced, 0);
    rst = 1'b0;
    idle(990);
    chk("not_synced_early", bus.synced, 0);
    idle(15);
    chk("synced_after_gap", bus.synced, 1);

    // single pixel, then latch
    mark();
    send_pixel(24'hA5C30F);
    idle(20);
    chk("t1_pv", n_pv - pv0, 1);
    chk("t1_be", n_be - be0, 0);
    exp_frm.push_back({1'b0, 16'd1});
    idle(1010);
    chk("t1_fd", n_fd - fd0, 1);

    // two pixels, latch, long idle
    mark();
    send_pixel(24'h000000);
    send_pixel(24'hFFFFFF);
    exp_frm.push_back({1'b0, 16'd2});
    idle(1010);
    chk("t2_pv", n_pv - pv0, 2);
    chk("t2_fd", n_fd - fd0, 1);
    idle(2000);
    chk("t2_no_second_fd", n_fd - fd0, 1);

    // threshold sweep: 11 -> 0, 12 -> 1, 24 -> 1, then 25 -> error
    mark();
    exp_pix.push_back({3'b011, 21'h0F0F0F});
    pulse(11, 14);
    pulse(12, 13);
    pulse(24, 10);
    send_bits(24'h0F0F0F, 21);
    send_bits(24'h00001A, 5);
    pulse(25, 10);
    chk("t3_be", n_be - be0, 1);
    chk("t3_synced_low", bus.synced, 0);
    chk("t3_pv", n_pv - pv0, 1);
    idle(1010);
    chk("t3_resynced", bus.synced, 1);
    send_pixel(24'h123456);
    exp_frm.push_back({1'b0, 16'd1});
    idle(1010);
    chk("t3_pv_after", n_pv - pv0, 2);
    chk("t3_fd", n_fd - fd0, 1);

    // glitch mid-pixel; following pixel ignored until latch
    mark();
    send_bits(24'h00005B, 7);
    pulse(2, 23);
    chk("t4_be", n_be - be0, 1);
    send_bits(24'hFFFFFF, 24);
    idle(20);
    chk("t4_no_pv", n_pv - pv0, 0);
    chk("t4_be_once", n_be - be0, 1);
    idle(1010);
    send_pixel(24'h5A5A5A);
    exp_frm.push_back({1'b0, 16'd1});
    idle(1010);
    chk("t4_pv", n_pv - pv0, 1);

    // partial pixel then latch
    mark();
    send_bits(24'h0002B5, 10);
    exp_frm.push_back({1'b1, 16'd0});
    idle(1010);
    chk("t5_fd", n_fd - fd0, 1);
    chk("t5_pixel_data_kept", bus.pixel_data, 24'h5A5A5A);
    chk("t5_pv", n_pv - pv0, 0);

    // async reset in the middle of a high pulse
    send_bits(24'h000ABC, 12);
    bus.sdi = 1'b1;
    repeat (5) @(negedge clk);
    #7 rst = 1'b1;
    #1;
    chk("ar_pixel_data", bus.pixel_data, 0);
    chk("ar_pixel_count", bus.pixel_count, 0);
    chk("ar_synced", bus.synced, 0);
    chk("ar_strobes", {bus.pixel_valid, bus.frame_done, bus.bit_err, bus.frame_err}, 0);
    @(negedge clk);
    bus.sdi = 1'b0;
    rst = 1'b0;
    mark();
    idle(1010);
    send_pixel(24'hC0FFEE);
    exp_frm.push_back({1'b0, 16'd1});
    idle(1010);
    chk("t6_pv", n_pv - pv0, 1);
    chk("t6_fd", n_fd - fd0, 1);
    chk("t6_be", n_be - be0, 0);

    chk("pix_queue_left", exp_pix.size(), 0);
    chk("frm_queue_left", exp_frm.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
